// File: rtl/ecc_scalar_mult_ctrl_if.sv
// Request/result and point-operation handshake bundle for the scalar-multiply controller.
// master = requester and point-unit side, slave = controller side.
interface ecc_scalar_mult_ctrl_if #(
    parameter int N  = 231,
    parameter int KW = 231
);
    logic          start;
    logic [KW-1:0] k;
    logic [N-1:0]  px;
    logic [N-1:0]  py;
    logic          p_inf;
    logic          busy;
    logic          done;
    logic [N-1:0]  qx;
    logic [N-1:0]  qy;
    logic          q_inf;
    logic          op_start;
    logic          op_dbl;
    logic [N-1:0]  op_x1;
    logic [N-1:0]  op_y1;
    logic [N-1:0]  op_x2;
    logic [N-1:0]  op_y2;
    logic          op_done;
    logic [N-1:0]  op_x3;
    logic [N-1:0]  op_y3;
    logic          op_inf3;

    modport master (
        output start, k, px, py, p_inf, op_done, op_x3, op_y3, op_inf3,
        input  busy, done, qx, qy, q_inf, op_start, op_dbl, op_x1, op_y1, op_x2, op_y2
    );

    modport slave (
        input  start, k, px, py, p_inf, op_done, op_x3, op_y3, op_inf3,
        output busy, done, qx, qy, q_inf, op_start, op_dbl, op_x1, op_y1, op_x2, op_y2
    );
endinterface

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*P driving an external point-op unit.
// Latency: 3 cycles per skipped bit plus op-unit wait time; waits indefinitely on op_done.
module ecc_scalar_mult_ctrl #(
    parameter int N  = 231,
    parameter int KW = 231
) (
    input  logic                   clk,
    input  logic                   reset,
    ecc_scalar_mult_ctrl_if.slave  bus
);
    localparam int IW = (KW > 1) ? $clog2(KW) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DBL,
        DBL_WAIT,
        CHK,
        ADD_WAIT,
        NEXT,
        DONE
    } state_t;

    state_t        state;
    logic [KW-1:0] k_q;
    logic [N-1:0]  px_q;
    logic [N-1:0]  py_q;
    logic          p_inf_q;
    logic [N-1:0]  rx;
    logic [N-1:0]  ry;
    logic          r_inf;
    logic [IW-1:0] idx;
    logic          op_ack;

    // The launch cycle itself never counts as completion, so a stale op_done cannot race a new op.
    assign op_ack = bus.op_done && !bus.op_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            k_q          <= '0;
            px_q         <= '0;
            py_q         <= '0;
            p_inf_q      <= 1'b0;
            rx           <= '0;
            ry           <= '0;
            r_inf        <= 1'b1;
            idx          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.qx       <= '0;
            bus.qy       <= '0;
            bus.q_inf    <= 1'b0;
            bus.op_start <= 1'b0;
            bus.op_dbl   <= 1'b0;
            bus.op_x1    <= '0;
            bus.op_y1    <= '0;
            bus.op_x2    <= '0;
            bus.op_y2    <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.op_start <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is still high in the done cycle, which masks a start arriving then.
                    bus.busy <= 1'b0;
                    if (bus.start && !bus.busy) begin
                        k_q      <= bus.k;
                        px_q     <= bus.px;
                        py_q     <= bus.py;
                        p_inf_q  <= bus.p_inf;
                        r_inf    <= 1'b1;
                        idx      <= IW'(KW - 1);
                        bus.busy <= 1'b1;
                        state    <= DBL;
                    end
                end
                DBL: begin
                    if (r_inf) begin
                        state <= CHK;
                    end else begin
                        bus.op_start <= 1'b1;
                        bus.op_dbl   <= 1'b1;
                        bus.op_x1    <= rx;
                        bus.op_y1    <= ry;
                        state        <= DBL_WAIT;
                    end
                end
                DBL_WAIT: begin
                    if (op_ack) begin
                        rx    <= bus.op_x3;
                        ry    <= bus.op_y3;
                        r_inf <= bus.op_inf3;
                        state <= CHK;
                    end
                end
                CHK: begin
                    if (!k_q[idx]) begin
                        state <= NEXT;
                    end else if (r_inf) begin
                        rx      <= px_q;
                        ry      <= py_q;
                        r_inf   <= p_inf_q;
                        state   <= NEXT;
                    end else if (!p_inf_q) begin
                        bus.op_start <= 1'b1;
                        bus.op_dbl   <= 1'b0;
                        bus.op_x1    <= rx;
                        bus.op_y1    <= ry;
                        bus.op_x2    <= px_q;
                        bus.op_y2    <= py_q;
                        state        <= ADD_WAIT;
                    end else begin
                        state <= NEXT;
                    end
                end
                ADD_WAIT: begin
                    if (op_ack) begin
                        rx    <= bus.op_x3;
                        ry    <= bus.op_y3;
                        r_inf <= bus.op_inf3;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx == '0) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx - IW'(1);
                        state <= DBL;
                    end
                end
                DONE: begin
                    bus.done  <= 1'b1;
                    bus.qx    <= rx;
                    bus.qy    <= ry;
                    bus.q_inf <= r_inf;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl on y^2 = x^3 + 2x + 2 mod 17 with a 3-cycle point-op model.
module tb_ecc_scalar_mult_ctrl;
    localparam int N      = 5;
    localparam int KW     = 5;
    localparam int BUDGET = 400;

    typedef struct {
        int x;
        int y;
        bit inf;
    } pt_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ecc_scalar_mult_ctrl_if #(.N(N), .KW(KW)) bus ();
    ecc_scalar_mult_ctrl_if #(.N(N), .KW(4))  bus4 ();

    ecc_scalar_mult_ctrl #(.N(N), .KW(KW)) dut  (.clk(clk), .reset(reset), .bus(bus));
    ecc_scalar_mult_ctrl #(.N(N), .KW(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

    int  tests_run    = 0;
    int  tests_failed = 0;
    int  pulse_cnt    = 0;
    int  op_seq       = 0;
    bit  last_dbl;
    pt_t last_a, last_b;
    pt_t G;

    function automatic int md(int v);
        return ((v % 17) + 17) % 17;
    endfunction

    function automatic int inv(int a);
        int r;
        r = 1;
        for (int e = 0; e < 15; e++) r = md(r * a);
        return r;
    endfunction

    // Full group law, including P+P and P+(-P).
    function automatic pt_t ec_add(pt_t a, pt_t b);
        pt_t r;
        int  l;
        if (a.inf) return b;
        if (b.inf) return a;
        r.inf = 1'b0;
        if (a.x == b.x) begin
            if (md(a.y + b.y) == 0) begin
                r.x = 0; r.y = 0; r.inf = 1'b1;
                return r;
            end
            l = md((3 * a.x * a.x + 2) * inv(md(2 * a.y)));
        end else begin
            l = md(md(b.y - a.y) * inv(md(b.x - a.x)));
        end
        r.x = md(l * l - a.x - b.x);
        r.y = md(l * (a.x - r.x) - a.y);
        return r;
    endfunction

    function automatic pt_t mul(int kv, pt_t p);
        pt_t r;
        r.x = 0; r.y = 0; r.inf = 1'b1;
        for (int i = 0; i < kv; i++) r = ec_add(r, p);
        return r;
    endfunction

    function automatic int exp_pulses(int kv, bit pinf);
        int pc, msb;
        pc = 0; msb = -1;
        if (kv == 0 || pinf) return 0;
        for (int b = 0; b < KW; b++) if (kv[b]) begin pc++; msb = b; end
        return (2 * pc - 2) + (msb + 1 - pc);
    endfunction

    // Counts every cycle op_start is high and remembers the last launched operation.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bus.op_start === 1'b1) begin
                pulse_cnt++;
                op_seq   = (op_seq << 1) | int'(bus.op_dbl);
                last_dbl = bus.op_dbl;
                last_a   = '{x: int'(bus.op_x1), y: int'(bus.op_y1), inf: 1'b0};
                last_b   = '{x: int'(bus.op_x2), y: int'(bus.op_y2), inf: 1'b0};
            end
        end
    end

    // Point-operation unit model: result valid 3 cycles after the op_start pulse.
    initial begin : unit_model
        pt_t a, b, r;
        bus.op_done = 1'b0; bus.op_x3 = '0; bus.op_y3 = '0; bus.op_inf3 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.op_start === 1'b1) begin
                a = '{x: int'(bus.op_x1), y: int'(bus.op_y1), inf: 1'b0};
                b = '{x: int'(bus.op_x2), y: int'(bus.op_y2), inf: 1'b0};
                r = bus.op_dbl ? ec_add(a, a) : ec_add(a, b);
                repeat (3) @(posedge clk);
                #1;
                bus.op_done = 1'b1; bus.op_x3 = N'(r.x); bus.op_y3 = N'(r.y); bus.op_inf3 = r.inf;
                @(posedge clk); #1;
                bus.op_done = 1'b0;
            end
        end
    end

    task automatic run_mult(input int kv, input pt_t p, output pt_t q, output int cyc,
                            output int pulses, output bit to, output bit clean_end);
        int base;
        base = pulse_cnt;
        bus.k = KW'(kv); bus.px = N'(p.x); bus.py = N'(p.y); bus.p_inf = p.inf; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0; to = 1'b1;
        for (int c = 0; c < BUDGET; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done === 1'b1) begin to = 1'b0; break; end
        end
        q.x = int'(bus.qx); q.y = int'(bus.qy); q.inf = bus.q_inf;
        pulses = pulse_cnt - base;
        @(posedge clk); #1;
        clean_end = (bus.done === 1'b0) && (bus.busy === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL rst_done got %b want 0", bus.done); end
        tests_run++; if (bus.op_start !== 1'b0 || bus.op_dbl !== 1'b0) begin tests_failed++; $display("FAIL rst_op_ctl got %b%b want 00", bus.op_start, bus.op_dbl); end
        tests_run++; if ({bus.qx, bus.qy, bus.q_inf} !== '0) begin tests_failed++; $display("FAIL rst_q got %h/%h/%b want 0", bus.qx, bus.qy, bus.q_inf); end
        tests_run++; if ({bus.op_x1, bus.op_y1, bus.op_x2, bus.op_y2} !== '0) begin tests_failed++; $display("FAIL rst_operands got %h want 0", {bus.op_x1, bus.op_y1, bus.op_x2, bus.op_y2}); end
        tests_run++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin tests_failed++; $display("FAIL rst_kw4 got busy %b done %b want 0", bus4.busy, bus4.done); end
        reset = 1'b0;
    endtask

    task automatic test_zero_latency();
        int cyc;
        bit saw_op, to, busy_at_done;
        bus4.k = '0; bus4.px = N'(5); bus4.py = N'(1); bus4.p_inf = 1'b0; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        cyc = 0; saw_op = 1'b0; to = 1'b1; busy_at_done = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus4.op_start === 1'b1) saw_op = 1'b1;
            if (bus4.done === 1'b1) begin to = 1'b0; busy_at_done = bus4.busy; break; end
        end
        tests_run++; if (to) begin tests_failed++; $display("FAIL k0_timeout no done within %0d cycles", BUDGET); end
        tests_run++; if (cyc != 13) begin tests_failed++; $display("FAIL k0_latency got %0d want 13", cyc); end
        tests_run++; if (bus4.q_inf !== 1'b1) begin tests_failed++; $display("FAIL k0_qinf got %b want 1", bus4.q_inf); end
        tests_run++; if (saw_op) begin tests_failed++; $display("FAIL k0_ops got op_start pulse want none"); end
        tests_run++; if (busy_at_done !== 1'b1) begin tests_failed++; $display("FAIL k0_busy_in_done got %b want 1", busy_at_done); end
        @(posedge clk); #1;
        tests_run++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin tests_failed++; $display("FAIL k0_end got busy %b done %b want 0 0", bus4.busy, bus4.done); end
    endtask

    task automatic test_k5();
        pt_t q; int cyc, pulses; bit to, ce;
        run_mult(5, G, q, cyc, pulses, to, ce);
        tests_run++; if (to) begin tests_failed++; $display("FAIL k5_timeout no done"); end
        tests_run++; if (pulses != 3) begin tests_failed++; $display("FAIL k5_pulses got %0d want 3", pulses); end
        tests_run++; if ((op_seq & 7) != 3'b110) begin tests_failed++; $display("FAIL k5_op_order got %b want 110", op_seq[2:0]); end
        tests_run++; if (q.inf !== 1'b0 || q.x != 9 || q.y != 16) begin tests_failed++; $display("FAIL k5_q got (%0d,%0d,%b) want (9,16,0)", q.x, q.y, q.inf); end
        tests_run++; if (!ce) begin tests_failed++; $display("FAIL k5_done_pulse done/busy not clear after done cycle"); end
    endtask

    task automatic test_k19();
        pt_t q; int cyc, pulses; bit to, ce;
        run_mult(19, G, q, cyc, pulses, to, ce);
        tests_run++; if (to) begin tests_failed++; $display("FAIL k19_timeout no done"); end
        tests_run++; if (q.inf !== 1'b1) begin tests_failed++; $display("FAIL k19_qinf got %b want 1", q.inf); end
        tests_run++; if (pulses != exp_pulses(19, 1'b0)) begin tests_failed++; $display("FAIL k19_pulses got %0d want %0d", pulses, exp_pulses(19, 1'b0)); end
        tests_run++;
        if (last_dbl !== 1'b0 || last_a.x != 5 || last_a.y != 16 || last_b.x != 5 || last_b.y != 1) begin
            tests_failed++;
            $display("FAIL k19_last_op got dbl=%b (%0d,%0d)+(%0d,%0d) want add (5,16)+(5,1)", last_dbl, last_a.x, last_a.y, last_b.x, last_b.y);
        end
    endtask

    task automatic test_p_inf();
        pt_t q, p; int cyc, pulses; bit to, ce;
        p = '{x: 5, y: 1, inf: 1'b1};
        run_mult(1, p, q, cyc, pulses, to, ce);
        tests_run++; if (to) begin tests_failed++; $display("FAIL pinf_timeout no done"); end
        tests_run++; if (q.inf !== 1'b1) begin tests_failed++; $display("FAIL pinf_qinf got %b want 1", q.inf); end
        tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL pinf_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_reset_midop();
        pt_t q; int cyc, pulses, base; bit to, ce, hit, quiet;
        base = pulse_cnt;
        bus.k = KW'(6); bus.px = N'(5); bus.py = N'(1); bus.p_inf = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(posedge clk); #2;
            if (pulse_cnt - base >= 3) begin hit = 1'b1; break; end
        end
        tests_run++; if (!hit) begin tests_failed++; $display("FAIL midop_timeout third op never launched"); end
        tests_run++; if ((op_seq & 7) != 3'b101) begin tests_failed++; $display("FAIL midop_op_order got %b want 101", op_seq[2:0]); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.op_start !== 1'b0 || bus.op_dbl !== 1'b0) begin tests_failed++; $display("FAIL midop_rst_ctl got busy %b done %b op_start %b op_dbl %b want 0", bus.busy, bus.done, bus.op_start, bus.op_dbl); end
        tests_run++; if ({bus.qx, bus.qy, bus.q_inf} !== '0) begin tests_failed++; $display("FAIL midop_rst_q got %h/%h/%b want 0", bus.qx, bus.qy, bus.q_inf); end
        tests_run++; if ({bus.op_x1, bus.op_y1, bus.op_x2, bus.op_y2} !== '0) begin tests_failed++; $display("FAIL midop_rst_operands got %h want 0", {bus.op_x1, bus.op_y1, bus.op_x2, bus.op_y2}); end
        quiet = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.op_start !== 1'b0 || bus.done !== 1'b0) quiet = 1'b0;
        end
        tests_run++; if (!quiet) begin tests_failed++; $display("FAIL midop_late_op_done DUT reacted while idle"); end
        run_mult(2, G, q, cyc, pulses, to, ce);
        tests_run++; if (to || q.inf !== 1'b0 || q.x != 6 || q.y != 3) begin tests_failed++; $display("FAIL midop_k2 got (%0d,%0d,%b) to=%b want (6,3,0)", q.x, q.y, q.inf, to); end
        tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL midop_k2_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_start_held();
        pt_t exp; int base, dones; bit to, b1, d1, b2;
        exp = mul(3, G);
        base = pulse_cnt;
        bus.k = KW'(3); bus.px = N'(G.x); bus.py = N'(G.y); bus.p_inf = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        dones = 0; to = 1'b1;
        for (int c = 0; c < BUDGET; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin dones++; to = 1'b0; break; end
        end
        @(posedge clk); #1;
        b1 = bus.busy; d1 = bus.done;
        @(posedge clk); #1;
        b2 = bus.busy;
        bus.start = 1'b0;
        tests_run++; if (to || b1 !== 1'b0 || d1 !== 1'b0) begin tests_failed++; $display("FAIL held_done_cycle got busy %b done %b to %b want 0 0 0", b1, d1, to); end
        tests_run++; if (b2 !== 1'b1) begin tests_failed++; $display("FAIL held_reaccept got busy %b want 1", b2); end
        to = 1'b1;
        for (int c = 0; c < BUDGET; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin dones++; to = 1'b0; break; end
        end
        tests_run++; if (to || dones != 2) begin tests_failed++; $display("FAIL held_second_run got %0d dones to=%b want 2", dones, to); end
        tests_run++; if (int'(bus.qx) != exp.x || int'(bus.qy) != exp.y || bus.q_inf !== exp.inf) begin tests_failed++; $display("FAIL held_q got (%0d,%0d,%b) want (%0d,%0d,%b)", bus.qx, bus.qy, bus.q_inf, exp.x, exp.y, exp.inf); end
        tests_run++; if (pulse_cnt - base != 2 * exp_pulses(3, 1'b0)) begin tests_failed++; $display("FAIL held_pulses got %0d want %0d", pulse_cnt - base, 2 * exp_pulses(3, 1'b0)); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        pt_t base, exp, q; int kv, j, cyc, pulses; bit to, ce;
        for (int it = 0; it < 24; it++) begin
            kv = $urandom_range(0, 31);
            j  = $urandom_range(0, 18);
            base = mul(j, G);
            if (base.inf) begin base.x = $urandom_range(0, 16); base.y = $urandom_range(0, 16); end
            exp = mul(kv, base);
            run_mult(kv, base, q, cyc, pulses, to, ce);
            tests_run++; if (to) begin tests_failed++; $display("FAIL rnd_timeout k=%0d j=%0d", kv, j); end
            tests_run++; if (q.inf !== exp.inf) begin tests_failed++; $display("FAIL rnd_qinf k=%0d j=%0d got %b want %b", kv, j, q.inf, exp.inf); end
            if (!exp.inf) begin
                tests_run++; if (q.x != exp.x || q.y != exp.y) begin tests_failed++; $display("FAIL rnd_q k=%0d j=%0d got (%0d,%0d) want (%0d,%0d)", kv, j, q.x, q.y, exp.x, exp.y); end
            end
            tests_run++; if (pulses != exp_pulses(kv, base.inf)) begin tests_failed++; $display("FAIL rnd_pulses k=%0d j=%0d got %0d want %0d", kv, j, pulses, exp_pulses(kv, base.inf)); end
            if (kv == 0) begin
                tests_run++; if (cyc != 3 * KW + 1) begin tests_failed++; $display("FAIL rnd_k0_latency got %0d want %0d", cyc, 3 * KW + 1); end
            end
            tests_run++; if (!ce) begin tests_failed++; $display("FAIL rnd_done_pulse k=%0d done/busy not clear after done cycle", kv); end
        end
    endtask

    initial begin
        G = '{x: 5, y: 1, inf: 1'b0};
        reset = 1'b1;
        bus.start = 1'b0; bus.k = '0; bus.px = '0; bus.py = '0; bus.p_inf = 1'b0;
        bus4.start = 1'b0; bus4.k = '0; bus4.px = '0; bus4.py = '0; bus4.p_inf = 1'b0;
        bus4.op_done = 1'b0; bus4.op_x3 = '0; bus4.op_y3 = '0; bus4.op_inf3 = 1'b0;
        test_reset();
        test_zero_latency();
        test_k5();
        test_k19();
        test_p_inf();
        test_reset_midop();
        test_start_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ecc_scalar_mult_ctrl.md
ECC_SCALAR_MULT_CTRL -- requirements
Module: ecc_scalar_mult_ctrl

Interface
REQ-001 Parameter N, default 231, field-element width in bits.
REQ-002 Parameter KW, default 231, scalar width in bits.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request a scalar multiplication; sampled only in IDLE.
REQ-006 k  in  KW  scalar; latched when start is accepted.
REQ-007 px, py  in  N  base point P; latched when start is accepted.
REQ-008 p_inf  in  1  P is the point at infinity; latched when start is accepted.
REQ-009 busy  out  1  high from the cycle after start is accepted through the DONE cycle.
REQ-010 done  out  1  one-cycle pulse when the result is valid.
REQ-011 qx, qy  out  N  result Q = k*P; held until the next accepted start.
REQ-012 q_inf  out  1  Q is the point at infinity; held with qx and qy.
REQ-013 op_start  out  1  one-cycle pulse that launches the external point-operation unit.
REQ-014 op_dbl  out  1  operation select: 1 = double (x1,y1), 0 = add (x1,y1)+(x2,y2).
REQ-015 op_x1, op_y1, op_x2, op_y2  out  N  operands; stable from the op_start cycle until op_done is accepted.
REQ-016 op_done  in  1  the external unit's result is valid.
REQ-017 op_x3, op_y3  in  N  result of the external unit.
REQ-018 op_inf3  in  1  the external unit's result is the point at infinity.

Function
REQ-019 Algorithm: left-to-right double-and-add. R = O; for i = KW-1 down to 0: R = 2R; if k[i] then R = R+P.
REQ-020 States: IDLE, DBL, DBL_WAIT, CHK, ADD_WAIT, NEXT, DONE.
REQ-021 IDLE, start=1: latch k, px, py, p_inf; set R = O and i = KW-1; go to DBL.
REQ-022 DBL, R = O: leave R = O, issue no operation, go to CHK.
REQ-023 DBL, R finite: pulse op_start with op_dbl=1 and op_x1/op_y1 = R; go to DBL_WAIT.
REQ-024 DBL_WAIT: on op_done, R <= (op_x3, op_y3, op_inf3); go to CHK.
REQ-025 CHK, k[i]=0: go to NEXT.
REQ-026 CHK, k[i]=1 and R = O: R <= P including p_inf, no operation; go to NEXT.
REQ-027 CHK, k[i]=1 and R finite and p_inf=0: pulse op_start with op_dbl=0, x1/y1 = R, x2/y2 = P; go to ADD_WAIT.
REQ-028 ADD_WAIT: on op_done, R <= result; go to NEXT.
REQ-029 NEXT: if i=0 go to DONE; otherwise i <= i-1 and go to DBL.
REQ-030 DONE: done=1 for one cycle; qx, qy, q_inf <= R in the same cycle; go to IDLE.
REQ-031 op_start is registered and is high in the first cycle of DBL_WAIT/ADD_WAIT only.
REQ-032 op_done is accepted only in a WAIT state in a cycle where op_start=0.
REQ-033 op_done is ignored in every other state and cycle.
REQ-034 start while busy=1 is ignored; a start asserted in the DONE cycle is ignored.
REQ-035 Each skipped bit (R = O, k[i]=0) costs 3 cycles: DBL, CHK, NEXT.
REQ-036 Latency of k=0 is exactly 3*KW cycles after the accept edge, with done in the next cycle.
REQ-037 The number of op_start pulses equals (2*popcount(k) - 2) + (bits below the MSB set that are 0), when k ≠ 0 and p_inf=0.
REQ-038 p_inf=1 yields q_inf=1 with zero op_start pulses.
REQ-039 op_inf3=1 from the unit is propagated; subsequent doubles and adds then follow REQ-022/REQ-026.

Reset
REQ-040 While reset=1, the state returns to IDLE on the next edge, including mid-operation.
REQ-041 Reset values: busy, done, op_start, op_dbl, qx, qy, q_inf, and all op_* operands = 0.
REQ-042 After reset, an op_done still pending from an interrupted operation is ignored (REQ-033).

Verification
Bench setup: N=5, KW=5 unless a scenario says otherwise. Curve y^2 = x^3 + 2x + 2 mod 17, P = (5,1). The model unit asserts op_done 3 cycles after op_start.
REQ-043 k=0, P=(5,1), KW=4 -> done exactly 13 cycles after the accept edge; q_inf=1; no op_start pulses.
REQ-044 k=5, P=(5,1) -> 3 op_start pulses (dbl, dbl, add); Q = (9,16); q_inf=0.
REQ-045 k=19, P=(5,1) -> final add is (5,16)+(5,1), the model returns op_inf3=1; q_inf=1.
REQ-046 k=1, p_inf=1 -> q_inf=1; zero op_start pulses.
REQ-047 k=6 with reset pulsed during the second DBL_WAIT, then a late op_done -> outputs return to reset values; late op_done is ignored; a fresh k=2 then gives Q = (6,3).
REQ-048 start held high through busy and the DONE cycle -> exactly one computation runs; the second start is accepted only in IDLE.
